serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//  Bit-serial adder/subtractor, the stage directly downstream of the conditional
//  ones'-complement unit. Takes operand A and operand B (the complementer's
//  output), injects the complement-select bit as carry-in so that B already
//  inverted plus 1 forms two's-complement subtraction, and produces the sum
//  LSB-first over W cycles. Result and status flags are held until the next
//  operation.
// PARAMETERS
//  W   4   operand/result width in bits (W >= 2)
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-high reset
//  A       in   W   operand A, sampled only on an accepted start
//  B       in   W   operand B (complementer output), sampled on an accepted start
//  cpl     in   1   complement select; used as carry-in, sampled on an accepted start
//  start   in   1   request; accepted only in IDLE
//  S       out  W   result register
//  cout    out  1   carry out of the MSB
//  ovf     out  1   signed overflow = carry into MSB XOR carry out of MSB
//  zero    out  1   1 when S == 0
//  busy    out  1   1 in SHIFT and DONE states
//  done    out  1   one-cycle pulse, result valid
// BEHAVIOUR
//  Reset (asynchronous, any state): state=IDLE; S=0, cout=0, ovf=0, zero=1,
//   busy=0, done=0; internal shift registers, carry and bit counter cleared.
//   A reset asserted mid-operation discards the operation; no done pulse.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: on an edge with start=1, load a_sh=A, b_sh=B, c=cpl, cnt=0, and go to
//    SHIFT. With start=0, stay in IDLE.
//   SHIFT: each edge computes s_bit = a_sh[0]^b_sh[0]^c and
//    c <= maj(a_sh[0], b_sh[0], c). It shifts a_sh and b_sh right and shifts
//    s_bit into a result shift register from the MSB side, then increments cnt.
//    Before the bit at cnt=W-1 is processed, it records c as the carry into the
//    MSB. On the edge with cnt=W-1, it transfers the completed result to S and
//    updates cout, ovf and zero in the same edge, then goes to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE on the next edge.
//  busy is a registered output, 1 in SHIFT and DONE.
//  Latency: start accepted at edge k gives S and flags updated at edge k+W,
//   and done high during the cycle following edge k+W.
//  Throughput: one operation per W+2 cycles; the earliest next accepted start
//   is at edge k+W+2.
//  start while busy=1 is ignored. It is neither queued nor able to corrupt the
//   operation in flight. Changes on A, B or cpl after acceptance have no effect.
//  S, cout, ovf and zero hold their values from the completed operation until
//   the next completion or reset. They do not change during SHIFT.
//  Arithmetic is modulo 2^W. cout is the unsigned carry, or the no-borrow
//   indicator when cpl=1. ovf uses the two's-complement interpretation.
// TESTING
//  1 Add: A=5, B=3, cpl=0, start -> after 4 edges S=8, cout=0, ovf=1, zero=0;
//    done is high for exactly 1 cycle.
//  2 Subtract: A=7, B=4'b1101 (~2), cpl=1 -> S=5, cout=1, ovf=0, zero=0.
//  3 Negative result: A=3, B=4'b1010 (~5), cpl=1 -> S=4'b1110, cout=0, ovf=0.
//  4 Wrap/zero: A=15, B=1, cpl=0 -> S=0, cout=1, ovf=0, zero=1;
//    separately A=8, B=4'b1110 (~1), cpl=1 -> S=7, ovf=1.
//  5 start held high, with A/B changed mid-op -> the result uses the values
//    latched at acceptance, and the next op is accepted exactly at edge k+6.
//  6 reset asserted at the 2nd SHIFT edge -> immediately (no clock needed)
//    S=0, zero=1, busy=0, and no done pulse. A following start completes normally.

Source files
------------

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial adder/subtractor. Operand B arrives already
//                ones'-complemented when cpl=1; cpl is injected as the
//                carry-in so the sum becomes A - B_original in two's
//                complement. The sum is formed LSB-first over W cycles and the
//                result plus flags are held until the next completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         cpl,
  input  logic         start,
  output logic [W-1:0] S,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam int                 c_cnt_w    = $clog2(W);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_c;
  logic [c_cnt_w-1:0] r_cnt;
  // Holds the W-1 sum bits already produced; the newest bit enters at the top.
  logic [W-2:0]       r_res;

  logic [W-1:0]       r_s;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic               w_sbit;
  logic               w_cnext;
  logic [W-1:0]       w_res_nxt;
  logic               w_last;

  // Full-adder slice on the current LSBs and the running carry.
  assign w_sbit    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cnext   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_res_nxt = {w_sbit, r_res};
  assign w_last    = (r_cnt == c_cnt_last);

  // State register together with the registered busy/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_shift;
      c_st_shift: if (w_last) w_state_nxt = c_st_done;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode from the next state so busy/done are clean registered flops.
  always_comb begin
    w_busy_nxt = (w_state_nxt == c_st_shift) || (w_state_nxt == c_st_done);
    w_done_nxt = (w_state_nxt == c_st_done);
  end

  // Datapath: latch operands on acceptance, shift one bit per SHIFT cycle,
  // publish result and flags on the final bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else if ((r_state == c_st_idle) && start) begin
      r_a   <= A;
      r_b   <= B;
      r_c   <= cpl;
      r_cnt <= '0;
    end else if (r_state == c_st_shift) begin
      r_a   <= {1'b0, r_a[W-1:1]};
      r_b   <= {1'b0, r_b[W-1:1]};
      r_c   <= w_cnext;
      r_res <= w_res_nxt[W-1:1];
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        // r_c here is the carry into the MSB; w_cnext is the carry out of it.
        r_s    <= w_res_nxt;
        r_cout <= w_cnext;
        r_ovf  <= r_c ^ w_cnext;
        r_zero <= (w_res_nxt == '0);
      end
    end
  end

  assign S    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire
